// File: rtl/app_mult16_seq_ctrl.sv
// Sequential signed 16x16 multiplier driving a shared 16x2 layer, one 2-bit slice per cycle.
// Optional macro APP_MULT_SKIP_ZERO_EN ends the run early once the remaining multiplier bits are 0.
module app_mult16_seq_ctrl #(
    parameter int unsigned width1 = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [width1-1:0]       A,
    input  logic [width1-1:0]       B,
    input  logic                    abort,
    output logic [width1-1:0]       layer_a,
    output logic                    layer_b_low,
    output logic                    layer_b_high,
    output logic                    layer_top,
    output logic                    layer_cin,
    input  logic [width1+1:0]       layer_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*width1-1:0]     product,
    output logic                    busy
);

    localparam int unsigned AccW = 2 * width1 + 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                 state_q;
    logic [2:0]             k_q;
    logic [width1-1:0]      a_q;
    logic [width1-1:0]      b_q;
    logic [AccW-1:0]        acc_q;
    logic [2*width1-1:0]    product_q;
    logic                   out_valid_q;

    logic [3:0]             shamt;
    logic [1:0]             slice;
    logic [AccW-1:0]        sum_ext;
    logic [AccW-1:0]        acc_next;
`ifdef APP_MULT_SKIP_ZERO_EN
    logic                   rest_zero;
`endif

    always_comb begin
        shamt    = {k_q, 1'b0};
        slice    = b_q[shamt +: 2];
        sum_ext  = {{(AccW - width1 - 2){layer_sum[width1+1]}}, layer_sum};
        // Slice k carries weight 4^k.
        acc_next = acc_q + (sum_ext << shamt);
`ifdef APP_MULT_SKIP_ZERO_EN
        rest_zero = ((b_q >> shamt) == '0);
`endif
    end

    always_comb begin
        in_ready     = (state_q == StIdle);
        busy         = (state_q != StIdle);
        out_valid    = out_valid_q;
        product      = product_q;
        layer_cin    = 1'b0;
        layer_a      = '0;
        layer_b_low  = 1'b0;
        layer_b_high = 1'b0;
        layer_top    = 1'b0;
        if (state_q == StRun) begin
            layer_a      = a_q;
            layer_b_low  = slice[0];
            layer_b_high = slice[1];
            layer_top    = (k_q == 3'd7);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end
`ifdef APP_MULT_SKIP_ZERO_EN
                    else if (rest_zero) begin
                        product_q   <= acc_q[2*width1-1:0];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
`endif
                    else begin
                        acc_q <= acc_next;
                        k_q   <= k_q + 3'd1;
                        if (k_q == 3'd7) begin
                            product_q   <= acc_next[2*width1-1:0];
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Abort and accept share the same exit; the result is simply not consumed.
                    if (abort || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule
